// File: rtl/bp_me_stream_arbiter_pkg.sv
// Widths and helpers shared by the bedrock memory stream arbiter and its
// round-robin core.
package bp_me_stream_arbiter_pkg;

   localparam int mem_msg_type_width_lp  = 4;
   localparam int mem_subop_width_lp     = 4;
   localparam int paddr_width_lp         = 40;
   localparam int mem_size_width_lp      = 3;
   localparam int mem_payload_width_lp   = 17;

   localparam int xce_mem_msg_header_width_lp = mem_msg_type_width_lp
                                              + mem_subop_width_lp
                                              + paddr_width_lp
                                              + mem_size_width_lp
                                              + mem_payload_width_lp;

   localparam int dword_width_p = 64;

   // Index of the requester that follows id, wrapping at n.
   function automatic int rr_next(input int id, input int n);
      return (id + 1 >= n) ? 0 : id + 1;
   endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin selector over a request vector; the priority pointer only moves
// when the caller reports a completed grant through yumi_i/yumi_id_i.
module bsg_arb_round_robin
   import bp_me_stream_arbiter_pkg::*;
#(
   parameter int width_p = 2,
   localparam int id_width_lp = $clog2(width_p)
)
(
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [width_p-1:0]     reqs_i,
   input  logic                   yumi_i,
   input  logic [id_width_lp-1:0] yumi_id_i,
   output logic [id_width_lp-1:0] sel_id_o
);

   logic [id_width_lp-1:0] ptr;
   logic [width_p-1:0]     rot;
   logic [id_width_lp:0]   sum;

   // With no request pending the selection rests on the pointer itself.
   always_comb begin
      rot      = width_p'({reqs_i, reqs_i} >> ptr);
      sel_id_o = ptr;
      sum      = '0;
      for (int k = width_p - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sum = {1'b0, ptr} + (id_width_lp + 1)'(k);
            if (sum >= (id_width_lp + 1)'(width_p))
               sum = sum - (id_width_lp + 1)'(width_p);
            sel_id_o = sum[id_width_lp-1:0];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)
         ptr <= '0;
      else if (yumi_i)
         ptr <= id_width_lp'(rr_next(int'(yumi_id_i), width_p));
   end

endmodule

// File: rtl/bp_me_stream_arbiter.sv
// Shares one bedrock memory stream bus among num_req_p requesters, holding the
// grant for the full length of a multi-beat message.
//
//   state    | meaning
//   e_idle   | arbitrating round-robin among valid requesters each cycle
//   e_locked | first beat of a multi-beat message sent; grant held to last
module bp_me_stream_arbiter
   import bp_me_stream_arbiter_pkg::*;
#(
   parameter int num_req_p      = 2,
   parameter int header_width_p = xce_mem_msg_header_width_lp,
   parameter int data_width_p   = dword_width_p,
   localparam int id_width_lp   = $clog2(num_req_p)
)
(
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic [num_req_p*header_width_p-1:0] req_header_i,
   input  logic [num_req_p*data_width_p-1:0]   req_data_i,
   input  logic [num_req_p-1:0]                req_v_i,
   input  logic [num_req_p-1:0]                req_last_i,
   output logic [num_req_p-1:0]                req_ready_and_o,
   output logic [header_width_p-1:0]           mem_header_o,
   output logic [data_width_p-1:0]             mem_data_o,
   output logic                                mem_v_o,
   output logic                                mem_last_o,
   input  logic                                mem_ready_and_i,
   output logic [id_width_lp-1:0]              grant_id_o,
   output logic                                locked_o
);

   typedef enum logic {e_idle, e_locked} state_e;

   state_e                 state;
   logic [id_width_lp-1:0] lock_id;
   logic [id_width_lp-1:0] sel_id;
   logic [id_width_lp-1:0] grant;
   logic                   v_raw;
   logic                   last_raw;
   logic                   hs;
   logic                   yumi;

   bsg_arb_round_robin #(
      .width_p (num_req_p)
   ) rr (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .reqs_i    (req_v_i),
      .yumi_i    (yumi),
      .yumi_id_i (grant),
      .sel_id_o  (sel_id)
   );

   always_comb begin
      if (reset_i)
         grant = '0;
      else if (state == e_locked)
         grant = lock_id;
      else
         grant = sel_id;
   end

   always_comb begin
      mem_header_o = '0;
      mem_data_o   = '0;
      v_raw        = 1'b0;
      last_raw     = 1'b0;
      for (int i = 0; i < num_req_p; i++) begin
         if (grant == id_width_lp'(i)) begin
            mem_header_o = req_header_i[i*header_width_p +: header_width_p];
            mem_data_o   = req_data_i[i*data_width_p +: data_width_p];
            v_raw        = req_v_i[i];
            last_raw     = req_last_i[i];
         end
      end
   end

   // The bus stays quiet during the reset cycle even if requesters are valid.
   assign mem_v_o    = v_raw & ~reset_i;
   assign mem_last_o = last_raw & mem_v_o;
   assign hs         = mem_v_o & mem_ready_and_i;
   assign yumi       = hs & last_raw;
   assign grant_id_o = grant;
   assign locked_o   = (state == e_locked);

   always_comb begin
      req_ready_and_o = '0;
      for (int i = 0; i < num_req_p; i++)
         req_ready_and_o[i] = hs & (grant == id_width_lp'(i));
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state   <= e_idle;
         lock_id <= '0;
      end else begin
         case (state)
            e_idle: begin
               if (hs & ~last_raw) begin
                  state   <= e_locked;
                  lock_id <= grant;
               end
            end
            e_locked: begin
               if (hs & last_raw)
                  state <= e_idle;
            end
            default: state <= e_idle;
         endcase
      end
   end

endmodule

// File: tb/tb_bp_me_stream_arbiter.sv
// Scoreboard bench for bp_me_stream_arbiter: a 2-requester instance for the
// lock/bubble/backpressure/reset scenarios and a 4-requester instance for rotation.
module tb_bp_me_stream_arbiter;

   typedef struct packed {
      logic [7:0] hdr;
      logic [7:0] dat;
      logic       last;
   } beat_t;

   typedef struct packed {
      int         cyc;
      logic       gid;
      logic [7:0] hdr;
      logic [7:0] dat;
      logic       last;
      logic       lk;
   } exp_t;

   typedef struct packed {
      int         cyc;
      logic       hs;
      logic       mv;
      logic [1:0] rdy;
      logic       lk;
      logic       gid;
      logic [7:0] hdr;
      logic [7:0] dat;
      logic       last;
   } mon_t;

   typedef struct packed {
      int         cyc;
      logic [1:0] gid;
      logic [7:0] hdr;
      logic       last;
      logic       lk;
   } exp4_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] req_header, req_data;
   logic [1:0]  req_v, req_last, req_ready;
   logic [7:0]  mem_header, mem_data;
   logic        mem_v, mem_last, mem_ready, locked, grant_id;

   logic [31:0] h4, d4;
   logic [3:0]  v4, last4, ready4;
   logic [7:0]  mh4, md4;
   logic        mv4, ml4, mr4, lk4;
   logic [1:0]  gid4;

   int     compared = 0;
   int     mism = 0;
   int     cyc, rst_at, stall_id, stall_lo, stall_hi, rdy_from;
   beat_t  src0[$];
   beat_t  src1[$];
   exp_t   sb[$];
   exp4_t  sb4[$];

   always #5 clk = ~clk;

   bp_me_stream_arbiter #(.num_req_p(2), .header_width_p(8), .data_width_p(8)) dut (
      .clk_i(clk), .reset_i(reset),
      .req_header_i(req_header), .req_data_i(req_data),
      .req_v_i(req_v), .req_last_i(req_last), .req_ready_and_o(req_ready),
      .mem_header_o(mem_header), .mem_data_o(mem_data), .mem_v_o(mem_v),
      .mem_last_o(mem_last), .mem_ready_and_i(mem_ready),
      .grant_id_o(grant_id), .locked_o(locked)
   );

   bp_me_stream_arbiter #(.num_req_p(4), .header_width_p(8), .data_width_p(8)) dut4 (
      .clk_i(clk), .reset_i(reset),
      .req_header_i(h4), .req_data_i(d4),
      .req_v_i(v4), .req_last_i(last4), .req_ready_and_o(ready4),
      .mem_header_o(mh4), .mem_data_o(md4), .mem_v_o(mv4),
      .mem_last_o(ml4), .mem_ready_and_i(mr4),
      .grant_id_o(gid4), .locked_o(lk4)
   );

   function automatic beat_t mk_beat(input int id, input int tag, input int k, input int n);
      beat_t b;
      b.hdr  = 8'(id * 16 + tag);
      b.dat  = 8'(tag * 16 + k);
      b.last = (k == n - 1);
      return b;
   endfunction

   function automatic exp_t mk_exp(input int c, input int id, input int tag,
                                   input int k, input int n, input logic lk);
      beat_t b;
      exp_t  e;
      b      = mk_beat(id, tag, k, n);
      e.cyc  = c;
      e.gid  = 1'(id);
      e.hdr  = b.hdr;
      e.dat  = b.dat;
      e.last = b.last;
      e.lk   = lk;
      return e;
   endfunction

   function automatic exp_t as_exp(input mon_t m);
      exp_t e;
      e.cyc  = m.cyc;
      e.gid  = m.gid;
      e.hdr  = m.hdr;
      e.dat  = m.dat;
      e.last = m.last;
      e.lk   = m.lk;
      return e;
   endfunction

   // One bus cycle: drive from the source queues at the negedge, sample 1ns later.
   task automatic step(output mon_t m);
      logic st0, st1;
      st0 = (stall_id == 0) && (cyc >= stall_lo) && (cyc <= stall_hi);
      st1 = (stall_id == 1) && (cyc >= stall_lo) && (cyc <= stall_hi);
      reset      = (cyc == rst_at);
      req_v      = '0;
      req_header = '0;
      req_data   = '0;
      req_last   = '0;
      if (src0.size() > 0 && !st0) begin
         req_v[0]         = 1'b1;
         req_header[7:0]  = src0[0].hdr;
         req_data[7:0]    = src0[0].dat;
         req_last[0]      = src0[0].last;
      end
      if (src1.size() > 0 && !st1) begin
         req_v[1]         = 1'b1;
         req_header[15:8] = src1[0].hdr;
         req_data[15:8]   = src1[0].dat;
         req_last[1]      = src1[0].last;
      end
      mem_ready = (cyc >= rdy_from);
      #1;
      m.cyc  = cyc;
      m.hs   = mem_v & mem_ready;
      m.mv   = mem_v;
      m.rdy  = req_ready;
      m.lk   = locked;
      m.gid  = grant_id;
      m.hdr  = mem_header;
      m.dat  = mem_data;
      m.last = mem_last;
      if (req_ready[0]) void'(src0.pop_front());
      if (req_ready[1]) void'(src1.pop_front());
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic setup(input int ra, input int rf);
      src0.delete();
      src1.delete();
      sb.delete();
      cyc      = 0;
      rst_at   = ra;
      rdy_from = rf;
      stall_id = -1;
      stall_lo = 0;
      stall_hi = -1;
   endtask

   task automatic test_reset();
      mon_t m;
      setup(0, 0);
      src0.push_back(mk_beat(0, 0, 0, 1));
      src1.push_back(mk_beat(1, 0, 0, 1));
      step(m);
      compared++;
      if (m.mv !== 1'b0) begin mism++; $display("FAIL reset_mem_v: got %b want 0", m.mv); end
      compared++;
      if (m.rdy !== 2'b00) begin mism++; $display("FAIL reset_ready: got %b want 00", m.rdy); end
      compared++;
      if (m.gid !== 1'b0) begin mism++; $display("FAIL reset_grant: got %b want 0", m.gid); end
      setup(-1, 0);
      step(m);
      compared++;
      if (m.lk !== 1'b0) begin mism++; $display("FAIL post_reset_locked: got %b want 0", m.lk); end
      compared++;
      if (m.gid !== 1'b0) begin mism++; $display("FAIL post_reset_grant: got %b want 0", m.gid); end
      compared++;
      if (m.mv !== 1'b0) begin mism++; $display("FAIL idle_mem_v: got %b want 0", m.mv); end
   endtask

   task automatic test_single_beat();
      mon_t m;
      exp_t e;
      setup(-1, 0);
      src0.push_back(mk_beat(0, 1, 0, 1));
      src0.push_back(mk_beat(0, 2, 0, 1));
      src1.push_back(mk_beat(1, 1, 0, 1));
      src1.push_back(mk_beat(1, 2, 0, 1));
      sb.push_back(mk_exp(0, 0, 1, 0, 1, 1'b0));
      sb.push_back(mk_exp(1, 1, 1, 0, 1, 1'b0));
      sb.push_back(mk_exp(2, 0, 2, 0, 1, 1'b0));
      sb.push_back(mk_exp(3, 1, 2, 0, 1, 1'b0));
      for (int t = 0; t < 12 && sb.size() > 0; t++) begin
         step(m);
         if (m.hs) begin
            compared++;
            e = sb.pop_front();
            if (as_exp(m) !== e) begin
               mism++;
               $display("FAIL single_beat: got %h want %h", as_exp(m), e);
            end
         end
      end
      compared++;
      if (sb.size() != 0) begin mism++; $display("FAIL single_drain: got %0d left want 0", sb.size()); end
   endtask

   task automatic test_burst();
      mon_t m;
      exp_t e;
      setup(-1, 0);
      for (int k = 0; k < 4; k++) begin
         src0.push_back(mk_beat(0, 3, k, 4));
         sb.push_back(mk_exp(k, 0, 3, k, 4, k > 0));
      end
      src1.push_back(mk_beat(1, 3, 0, 1));
      sb.push_back(mk_exp(4, 1, 3, 0, 1, 1'b0));
      for (int t = 0; t < 12 && sb.size() > 0; t++) begin
         step(m);
         if (m.hs) begin
            compared++;
            e = sb.pop_front();
            if (as_exp(m) !== e) begin
               mism++;
               $display("FAIL burst: got %h want %h", as_exp(m), e);
            end
         end
      end
      compared++;
      if (sb.size() != 0) begin mism++; $display("FAIL burst_drain: got %0d left want 0", sb.size()); end
   endtask

   task automatic test_bubble();
      mon_t m;
      exp_t e;
      setup(-1, 0);
      stall_id = 0;
      stall_lo = 1;
      stall_hi = 3;
      for (int k = 0; k < 4; k++) src0.push_back(mk_beat(0, 4, k, 4));
      src1.push_back(mk_beat(1, 4, 0, 1));
      sb.push_back(mk_exp(0, 0, 4, 0, 4, 1'b0));
      sb.push_back(mk_exp(4, 0, 4, 1, 4, 1'b1));
      sb.push_back(mk_exp(5, 0, 4, 2, 4, 1'b1));
      sb.push_back(mk_exp(6, 0, 4, 3, 4, 1'b1));
      sb.push_back(mk_exp(7, 1, 4, 0, 1, 1'b0));
      for (int t = 0; t < 14 && sb.size() > 0; t++) begin
         step(m);
         if (m.cyc >= 1 && m.cyc <= 3) begin
            compared++;
            if ({m.mv, m.rdy, m.lk} !== 4'b0001) begin
               mism++;
               $display("FAIL bubble_hold c%0d: got v=%b rdy=%b lk=%b want v=0 rdy=00 lk=1",
                        m.cyc, m.mv, m.rdy, m.lk);
            end
         end
         if (m.hs) begin
            compared++;
            e = sb.pop_front();
            if (as_exp(m) !== e) begin
               mism++;
               $display("FAIL bubble: got %h want %h", as_exp(m), e);
            end
         end
      end
      compared++;
      if (sb.size() != 0) begin mism++; $display("FAIL bubble_drain: got %0d left want 0", sb.size()); end
   endtask

   task automatic test_backpressure();
      mon_t  m;
      exp_t  e;
      beat_t b;
      setup(-1, 5);
      b = mk_beat(1, 5, 0, 1);
      src1.push_back(b);
      sb.push_back(mk_exp(5, 1, 5, 0, 1, 1'b0));
      for (int t = 0; t < 12 && sb.size() > 0; t++) begin
         step(m);
         if (m.cyc < 5) begin
            compared++;
            if ({m.mv, m.gid, m.rdy, m.hdr} !== {1'b1, 1'b1, 2'b00, b.hdr}) begin
               mism++;
               $display("FAIL backpressure_hold c%0d: got v=%b g=%b rdy=%b h=%h want v=1 g=1 rdy=00 h=%h",
                        m.cyc, m.mv, m.gid, m.rdy, m.hdr, b.hdr);
            end
         end
         if (m.hs) begin
            compared++;
            e = sb.pop_front();
            if (as_exp(m) !== e) begin
               mism++;
               $display("FAIL backpressure: got %h want %h", as_exp(m), e);
            end
         end
      end
      compared++;
      if (sb.size() != 0) begin mism++; $display("FAIL backpressure_drain: got %0d left want 0", sb.size()); end
   endtask

   task automatic test_reset_mid();
      mon_t m;
      exp_t e;
      setup(1, 0);
      for (int k = 0; k < 4; k++) src1.push_back(mk_beat(1, 6, k, 4));
      sb.push_back(mk_exp(0, 1, 6, 0, 4, 1'b0));
      sb.push_back(mk_exp(2, 0, 6, 0, 1, 1'b0));
      sb.push_back(mk_exp(3, 1, 6, 1, 4, 1'b0));
      sb.push_back(mk_exp(4, 1, 6, 2, 4, 1'b1));
      sb.push_back(mk_exp(5, 1, 6, 3, 4, 1'b1));
      for (int t = 0; t < 14 && sb.size() > 0; t++) begin
         if (cyc == 2) src0.push_back(mk_beat(0, 6, 0, 1));
         step(m);
         if (m.cyc == 1) begin
            compared++;
            if (m.mv !== 1'b0) begin mism++; $display("FAIL reset_mid_mem_v: got %b want 0", m.mv); end
         end
         if (m.cyc == 2) begin
            compared++;
            if (m.lk !== 1'b0) begin mism++; $display("FAIL reset_mid_unlock: got %b want 0", m.lk); end
         end
         if (m.hs) begin
            compared++;
            e = sb.pop_front();
            if (as_exp(m) !== e) begin
               mism++;
               $display("FAIL reset_mid: got %h want %h", as_exp(m), e);
            end
         end
      end
      compared++;
      if (sb.size() != 0) begin mism++; $display("FAIL reset_mid_drain: got %0d left want 0", sb.size()); end
   endtask

   task automatic test_four_way();
      int    cnt[4];
      exp4_t e, got;
      reset = 1'b0;
      cyc   = 0;
      sb4.delete();
      for (int i = 0; i < 4; i++) cnt[i] = 2;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 4; i++) begin
            e.cyc  = r * 4 + i;
            e.gid  = 2'(i);
            e.hdr  = 8'(i * 16 + r);
            e.last = 1'b1;
            e.lk   = 1'b0;
            sb4.push_back(e);
         end
      for (int t = 0; t < 16 && sb4.size() > 0; t++) begin
         for (int i = 0; i < 4; i++) begin
            v4[i]          = (cnt[i] > 0);
            h4[i*8 +: 8]   = 8'(i * 16 + (2 - cnt[i]));
            d4[i*8 +: 8]   = 8'(i);
            last4[i]       = 1'b1;
         end
         mr4 = 1'b1;
         #1;
         if (mv4 && mr4) begin
            compared++;
            got.cyc  = cyc;
            got.gid  = gid4;
            got.hdr  = mh4;
            got.last = ml4;
            got.lk   = lk4;
            e = sb4.pop_front();
            if (got !== e) begin
               mism++;
               $display("FAIL four_way: got %h want %h", got, e);
            end
         end
         for (int i = 0; i < 4; i++) if (ready4[i]) cnt[i]--;
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      compared++;
      if (sb4.size() != 0) begin mism++; $display("FAIL four_way_drain: got %0d left want 0", sb4.size()); end
      v4 = '0;
   endtask

   initial begin
      reset      = 1'b0;
      req_v      = '0;
      req_header = '0;
      req_data   = '0;
      req_last   = '0;
      mem_ready  = 1'b0;
      v4         = '0;
      h4         = '0;
      d4         = '0;
      last4      = '0;
      mr4        = 1'b0;
      setup(-1, 0);
      @(negedge clk);
      test_reset();
      test_single_beat();
      test_burst();
      test_bubble();
      test_backpressure();
      test_reset_mid();
      test_four_way();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end

endmodule
